mem_access_ctrl: RTL and testbench

- Memory access controller directly downstream of the memory address register.
- Takes the latched 15-bit address from the address register plus a read or write command, and runs one transaction on the external memory port using a ready handshake with a timeout.
- Returns read data to the data-register path and reports completion or timeout to the control unit.

---
 rtl/mem_access_ctrl_if.sv | 23 ++
 rtl/mem_access_ctrl.sv | 110 +++++++++++
 tb/tb_mem_access_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// External memory port of the access controller: request strobe, address/data
// outbound, and the ready/read-data acknowledge coming back from memory.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_en;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_addr, mem_wdata, mem_en, mem_we,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_en, mem_we,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Runs one read or write on the external memory port per start command, waiting
// for mem_ready up to TIMEOUT cycles, then reports done/err for one cycle.
module mem_access_ctrl #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              start_rd,
  input  logic              start_wr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata_out,
  mem_access_ctrl_if.master mem
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t            state_reg, state_next;
  logic              we_reg, we_next;
  logic              err_reg, err_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      we_reg    <= 1'b0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      we_reg    <= we_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    we_next    = we_reg;
    err_next   = err_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    case (state_reg)
      IDLE: begin
        if (start_rd || start_wr) begin
          addr_next  = addr_in;
          wdata_next = wdata_in;
          // Read takes priority when both commands arrive together.
          we_next    = start_wr & ~start_rd;
          err_next   = 1'b0;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        cnt_next   = '0;
        state_next = WAIT;
      end
      WAIT: begin
        // Ready is checked before the timeout so a late ack still counts as good.
        if (mem.mem_ready) begin
          if (!we_reg) begin
            rdata_next = mem.mem_rdata;
          end
          err_next   = 1'b0;
          state_next = DONE;
        end else if (cnt_reg == CNT_LAST) begin
          err_next   = 1'b1;
          state_next = DONE;
        end else if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DONE: begin
        err_next   = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy          = (state_reg != IDLE);
  assign done          = (state_reg == DONE);
  assign err           = (state_reg == DONE) && err_reg;
  assign rdata_out     = rdata_reg;
  assign mem.mem_en    = (state_reg == ACCESS) || (state_reg == WAIT);
  assign mem.mem_we    = mem.mem_en && we_reg;
  assign mem.mem_addr  = addr_reg;
  assign mem.mem_wdata = wdata_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: table of single transactions with
// hand-computed done cycles, plus reset-abort and back-to-back sequences.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic [14:0] addr_in;
  logic [15:0] wdata_in;
  logic        start_rd;
  logic        start_wr;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] rdata_out;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl_if #(.ADDR_W(15), .DATA_W(16)) mif ();

  mem_access_ctrl #(.ADDR_W(15), .DATA_W(16), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr_in   (addr_in),
    .wdata_in  (wdata_in),
    .start_rd  (start_rd),
    .start_wr  (start_wr),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata_out (rdata_out),
    .mem       (mif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [14:0] addr;
    logic [15:0] wdata;
    int          ready_at;    // cycle in which mem_ready is high, -1 = never
    logic [15:0] rdata;       // memory data returned with ready
    int          done_c;      // cycle in which done is expected
    logic        exp_err;
    logic        exp_we;
    logic [15:0] exp_rdata;
    logic        busy_pulse;  // pulse start_wr during busy
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 15'h1234, 16'h0000, 2, 16'hBEEF, 3, 1'b0, 1'b0, 16'hBEEF, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 15'h7FFF, 16'hA5A5, 5, 16'hCCCC, 6, 1'b0, 1'b1, 16'hBEEF, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 15'h0100, 16'h0000, -1, 16'hDEAD, 10, 1'b1, 1'b0, 16'hBEEF, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 15'h0000, 16'h5A5A, 2, 16'h0F0F, 3, 1'b0, 1'b0, 16'h0F0F, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 15'h0001, 16'h0000, 3, 16'h1357, 4, 1'b0, 1'b0, 16'h1357, 1'b0};

    rst_n = 1'b0; addr_in = '0; wdata_in = '0; start_rd = 1'b0; start_wr = 1'b0;
    mif.mem_ready = 1'b0; mif.mem_rdata = 16'hDEAD;
    repeat (2) @(negedge clk);
    check("reset_ctrl", {28'd0, mif.mem_en, mif.mem_we, busy, done}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_data", {rdata_out, mif.mem_wdata}, 32'd0);
    check("reset_addr", {17'd0, mif.mem_addr}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      $display("txn %0d: rd=%0b wr=%0b addr=%h wdata=%h expect done@%0d err=%0b",
               v, vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata,
               vecs[v].done_c, vecs[v].exp_err);
      start_rd = vecs[v].rd; start_wr = vecs[v].wr;
      addr_in = vecs[v].addr; wdata_in = vecs[v].wdata;
      for (int k = 1; k <= vecs[v].done_c + 1; k++) begin
        @(negedge clk);
        start_rd = 1'b0; start_wr = 1'b0;
        addr_in = 15'h2AAA; wdata_in = 16'h1111;
        if (vecs[v].busy_pulse && k == 2) start_wr = 1'b1;
        mif.mem_ready = (k == vecs[v].ready_at);
        mif.mem_rdata = mif.mem_ready ? vecs[v].rdata : 16'hDEAD;
        check($sformatf("t%0d_c%0d_ctrl", v, k),
              {28'd0, mif.mem_en, busy, done, err},
              {28'd0, k < vecs[v].done_c, k <= vecs[v].done_c,
               k == vecs[v].done_c, (k == vecs[v].done_c) && vecs[v].exp_err});
        if (k < vecs[v].done_c)
          check($sformatf("t%0d_c%0d_bus", v, k),
                {mif.mem_we, mif.mem_addr, mif.mem_wdata},
                {vecs[v].exp_we, vecs[v].addr, vecs[v].wdata});
      end
      start_wr = 1'b0;
      mif.mem_ready = 1'b0;
      check($sformatf("t%0d_rdata", v), {16'd0, rdata_out}, {16'd0, vecs[v].exp_rdata});
      @(negedge clk);
      check($sformatf("t%0d_idle", v), {30'd0, busy, mif.mem_en}, 32'd0);
    end

    // Reset in the middle of WAIT aborts immediately, without a clock edge.
    $display("txn reset_abort: read at 0x0003, reset asserted in WAIT");
    start_rd = 1'b1; addr_in = 15'h0003;
    @(negedge clk); start_rd = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_pre_en", {31'd0, mif.mem_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ctrl", {28'd0, mif.mem_en, busy, done, err}, 32'd0);
    check("abort_rdata", {16'd0, rdata_out}, 32'd0);
    check("abort_addr", {17'd0, mif.mem_addr}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("abort_idle", {30'd0, busy, mif.mem_en}, 32'd0);

    // Holding start_rd with zero-wait memory yields one done every 4 cycles.
    $display("txn back_to_back: start_rd held, ready held, expect done every 4 cycles");
    start_rd = 1'b1; addr_in = 15'h0055;
    mif.mem_ready = 1'b1; mif.mem_rdata = 16'h2468;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("b2b_c%0d", k), {30'd0, done, err}, {30'd0, (k % 4) == 3, 1'b0});
    end
    start_rd = 1'b0; mif.mem_ready = 1'b0;
    check("b2b_rdata", {16'd0, rdata_out}, 32'h0000_2468);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
